sys_rst_sequencer: RTL and testbench
====================================

# sys_rst_sequencer

Consumes the asynchronous `locked` indications of the camera, MIG-reference and video PLLs and turns them into an ordered, glitch-free reset release for the downstream domains. It runs on the free-running board clock that feeds the PLLs, sits directly behind the clock-generation block, and is the single source of system-level reset requests. It also monitors the locks continuously and re-runs the sequence after any loss of lock.

## Interface
- `NUM_PLL`, 3: number of PLL lock inputs.
- `NUM_RST`, 4: number of sequenced reset outputs; bit 0 is released first.
- `LOCK_STABLE_CYCLES`, 1024: contiguous all-locked cycles required before release starts; minimum 2.
- `STEP_CYCLES`, 256: cycles between successive reset releases; minimum 1.
- `HOLD_CYCLES`, 64: cycles spent in FAULT with all resets asserted; minimum 1.
- `TIMEOUT_CYCLES`, 2^20: lock watchdog limit; used only with `SYS_RST_WDOG_EN`.

- `clk`  in  1  board clock; the same clock that drives the PLL inputs.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pll_locked`  in  NUM_PLL  raw PLL lock flags; asynchronous to `clk`.
- `rst_seq_n`  out  NUM_RST  active-low reset requests to the downstream domains, registered.
- `init_done`  out  1  high while all resets are released (RUN state).
- `lock_loss_cnt`  out  8  count of lock losses seen in RELEASE or RUN; saturates at 255.
- `wdog_timeout`  out  1  sticky watchdog flag.

## Operation
- Each `pll_locked` bit passes through its own 2-flop synchronizer. `all_locked` is the AND of the synchronized bits.
- States:
  - **WAIT_LOCK:** all `rst_seq_n` are 0 and the stable counter is cleared. Go to STABLE when `all_locked`=1.
  - **STABLE:** the stable counter increments each cycle `all_locked`=1.
    - If `all_locked` drops, return to WAIT_LOCK. This is not counted as a loss.
    - When the counter reaches `LOCK_STABLE_CYCLES-1`, go to RELEASE and clear the step counter.
  - **RELEASE:** the step counter increments each cycle.
    - Each time it reaches `STEP_CYCLES-1` it wraps to 0 and `rst_seq_n[k]` is set to 1, for k = 0, 1, … in order.
    - In the cycle where bit `NUM_RST-1` is set, go to RUN.
  - **RUN:** all `rst_seq_n` are 1 and `init_done`=1.
  - **FAULT:** all `rst_seq_n` are 0 and `init_done`=0. Stay for `HOLD_CYCLES` cycles, then go to WAIT_LOCK whatever the lock state.
- Lock loss: `all_locked`=0 in RELEASE or RUN moves the block to FAULT and increments `lock_loss_cnt`, saturating at 255.
- Released bits stay released until FAULT or reset. A bit is never re-asserted individually.
- Simultaneous events: a lock drop in the same cycle as a release step wins. The block goes to FAULT, no further bit is released, and all bits are cleared on the next edge.

## Timing
- Reset values: `rst_seq_n`=0, `init_done`=0, `lock_loss_cnt`=0, `wdog_timeout`=0, state WAIT_LOCK. Reset applies asynchronously, mid-sequence included.
- Lock-in to `all_locked` latency: 2 `clk` edges.
- `all_locked` high to RELEASE entry: `LOCK_STABLE_CYCLES`+1 edges.
- `rst_seq_n[k]` rises `(k+1)*STEP_CYCLES` edges after RELEASE entry. `init_done` rises on the same edge as `rst_seq_n[NUM_RST-1]`.
- `all_locked` low in RUN: all `rst_seq_n` are 0 and `init_done` is 0 on the next edge. The raw lock drop reaches the outputs 3 edges later.
- All outputs are registered with no combinational path from inputs.

## Configuration
- `SYS_RST_WDOG_EN` defined:
  - A watchdog counter runs while the block is in WAIT_LOCK or STABLE and clears in every other state.
  - When it reaches `TIMEOUT_CYCLES-1`, `wdog_timeout` is set. It stays set until `rst_n`.
  - The sequence itself is not affected.
- Undefined: no watchdog logic; `wdog_timeout` is tied to 0.

## Structure
- Package `sys_rst_pkg` holds the state enum (WAIT_LOCK, STABLE, RELEASE, RUN, FAULT) and the loss-counter width constant `LOSS_CNT_W`=8.
- One sub-module, `lock_sync_2ff`: a single-bit 2-flop synchronizer with asynchronous active-low reset to 0, instantiated `NUM_PLL` times.
- Counter widths are `$clog2` of the largest of the relevant parameters.

## Test plan
Test parameters: `NUM_PLL`=3, `NUM_RST`=3, `LOCK_STABLE_CYCLES`=16, `STEP_CYCLES`=4, `HOLD_CYCLES`=8.
- **Clean bring-up.** Raise all locks together → RELEASE entered 19 edges later; `rst_seq_n` goes 001, 011, 111 at +4, +8 and +12; `init_done`=1 at +12.
- **Lock glitch during STABLE.** Drop one lock for 3 cycles at stable count 10 → return to WAIT_LOCK, full 16-cycle count restarts, `lock_loss_cnt` stays 0.
- **Loss in RUN.** Drop `pll_locked[1]` → after 3 edges `rst_seq_n`=000 and `init_done`=0; `lock_loss_cnt`=1; 8 cycles in FAULT; the sequence reruns once locks return.
- **Loss coincident with the second release step.** `rst_seq_n` never shows 011; it goes 001 then 000.
- **Mid-sequence reset.** Assert `rst_n` low during RELEASE → all outputs go to reset values immediately, without waiting for an edge.
- **Watchdog (`SYS_RST_WDOG_EN` defined, `TIMEOUT_CYCLES`=100).** Hold locks low → `wdog_timeout` rises at edge 100 and stays high after the locks later arrive.

Source files
------------

// File: rtl/sys_rst_pkg.sv
// Shared types and constants for the system reset sequencer.
// The sequencer FSM states and the lock-loss counter width live here.
package sys_rst_pkg;

    localparam int LOSS_CNT_W = 8;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } rst_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sys_rst_sequencer_lock_sync_2ff.sv
// Single-bit two-flop synchronizer for an asynchronous PLL lock flag.
// Both flops clear to 0 on reset so a fresh lock must propagate again.
module lock_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/sys_rst_sequencer.sv
// Ordered reset release driven by synchronized PLL lock flags, with lock-loss recovery.
// Optional lock watchdog is built only when SYS_RST_WDOG_EN is defined.
module sys_rst_sequencer
    import sys_rst_pkg::*;
#(
    parameter int NUM_PLL            = 3,
    parameter int NUM_RST            = 4,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STEP_CYCLES        = 256,
    parameter int HOLD_CYCLES        = 64,
    parameter int TIMEOUT_CYCLES     = 1 << 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_PLL-1:0]    pll_locked,
    output logic [NUM_RST-1:0]    rst_seq_n,
    output logic                  init_done,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic                  wdog_timeout
);

    // One counter is shared by STABLE, RELEASE and FAULT since only one runs at a time.
    localparam int CNT_MAX = max3(LOCK_STABLE_CYCLES, STEP_CYCLES, HOLD_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    logic [NUM_PLL-1:0]    locked_sync;
    logic                  all_locked;
    rst_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_RST-1:0]    rst_seq_n_q;
    logic                  init_done_q;
    logic [LOSS_CNT_W-1:0] loss_cnt_q;
    logic [NUM_RST-1:0]    rel_next_d;
    logic                  lock_lost_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLL; gi++) begin : g_sync
            lock_sync_2ff u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d_i   (pll_locked[gi]),
                .q_o   (locked_sync[gi])
            );
        end
    endgenerate

    assign all_locked = &locked_sync;

    // Bits are released LSB first, so the next pattern is a shift-in of a 1.
    assign rel_next_d  = (rst_seq_n_q << 1) | NUM_RST'(1);
    assign lock_lost_d = !all_locked && ((state_q == RELEASE) || (state_q == RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            rst_seq_n_q <= '0;
            init_done_q <= 1'b0;
            loss_cnt_q  <= '0;
        end else if (lock_lost_d) begin
            // A lock drop outranks a coincident release step.
            state_q     <= FAULT;
            cnt_q       <= '0;
            rst_seq_n_q <= '0;
            init_done_q <= 1'b0;
            if (loss_cnt_q != {LOSS_CNT_W{1'b1}}) begin
                loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
            end
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    cnt_q       <= '0;
                    rst_seq_n_q <= '0;
                    init_done_q <= 1'b0;
                    if (all_locked) begin
                        state_q <= STABLE;
                    end
                end
                STABLE: begin
                    if (!all_locked) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_q       <= '0;
                        rst_seq_n_q <= rel_next_d;
                        if (&rel_next_d) begin
                            state_q     <= RUN;
                            init_done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    rst_seq_n_q <= '1;
                    init_done_q <= 1'b1;
                end
                FAULT: begin
                    rst_seq_n_q <= '0;
                    init_done_q <= 1'b0;
                    if (cnt_q == HOLD_LAST) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= WAIT_LOCK;
                    cnt_q       <= '0;
                    rst_seq_n_q <= '0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign rst_seq_n     = rst_seq_n_q;
    assign init_done     = init_done_q;
    assign lock_loss_cnt = loss_cnt_q;

`ifdef SYS_RST_WDOG_EN
    localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_q;
    logic              wdog_timeout_q;

    // Counts only while waiting for locks; the flag is sticky until rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q     <= '0;
            wdog_timeout_q <= 1'b0;
        end else if ((state_q == WAIT_LOCK) || (state_q == STABLE)) begin
            if (wdog_cnt_q == WDOG_LAST) begin
                wdog_timeout_q <= 1'b1;
            end else begin
                wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
            end
        end else begin
            wdog_cnt_q <= '0;
        end
    end

    assign wdog_timeout = wdog_timeout_q;
`else
    // No watchdog in this build: the flag is constant low.
    assign wdog_timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_sys_rst_sequencer.sv
// Scoreboard bench for sys_rst_sequencer: stimulus queues expected output changes,
// a negedge monitor pops and compares each change including the edge it occurred on.
module tb_sys_rst_sequencer;

    localparam int NUM_PLL = 3;
    localparam int NUM_RST = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NUM_PLL-1:0]  pll_locked;
    logic [NUM_RST-1:0]  rst_seq_n;
    logic                init_done;
    logic [7:0]          lock_loss_cnt;
    logic                wdog_timeout;

    sys_rst_sequencer #(
        .NUM_PLL            (NUM_PLL),
        .NUM_RST            (NUM_RST),
        .LOCK_STABLE_CYCLES (16),
        .STEP_CYCLES        (4),
        .HOLD_CYCLES        (8),
        .TIMEOUT_CYCLES     (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .rst_seq_n     (rst_seq_n),
        .init_done     (init_done),
        .lock_loss_cnt (lock_loss_cnt),
        .wdog_timeout  (wdog_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       done;
        logic [7:0] loss;
        logic       wdog;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic  wd       = 1'b0;
    logic [12:0] prev_obs = 13'd0;

    task automatic push(input int c, input logic [2:0] r, input logic d, input logic [7:0] l);
        exp_t e;
        e.cyc  = c;
        e.rst  = r;
        e.done = d;
        e.loss = l;
        e.wdog = wd;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_now(input string name);
        n_checks++;
        if (rst_seq_n !== 3'b000 || init_done !== 1'b0 || lock_loss_cnt !== 8'd0 || wdog_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got rst=%b done=%b loss=%0d wdog=%b, required rst=000 done=0 loss=0 wdog=0",
                     name, rst_seq_n, init_done, lock_loss_cnt, wdog_timeout);
        end else begin
            $display("ok   %s: outputs at reset values", name);
        end
    endtask

    // Monitor: every observed output change must match the head of the queue.
    always @(negedge clk) begin
        logic [12:0] obs;
        exp_t        e;
        obs = {rst_seq_n, init_done, lock_loss_cnt, wdog_timeout};
        if (obs !== prev_obs) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change cyc=%0d: got rst=%b done=%b loss=%0d wdog=%b, required no change",
                         cyc, rst_seq_n, init_done, lock_loss_cnt, wdog_timeout);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.rst !== rst_seq_n || e.done !== init_done ||
                    e.loss !== lock_loss_cnt || e.wdog !== wdog_timeout) begin
                    n_fail++;
                    $display("FAIL output_change: got cyc=%0d rst=%b done=%b loss=%0d wdog=%b, required cyc=%0d rst=%b done=%b loss=%0d wdog=%b",
                             cyc, rst_seq_n, init_done, lock_loss_cnt, wdog_timeout,
                             e.cyc, e.rst, e.done, e.loss, e.wdog);
                end else begin
                    $display("ok   cyc=%0d rst=%b done=%b loss=%0d wdog=%b",
                             cyc, rst_seq_n, init_done, lock_loss_cnt, wdog_timeout);
                end
            end
            prev_obs = obs;
        end
    end

    initial begin
        int r0, a, b, c, d, g, e, f;
        rst_n      = 1'b1;
        pll_locked = '0;
        #1 rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        check_now("reset_state");
        rst_n = 1'b1;
        r0    = cyc;
`ifdef SYS_RST_WDOG_EN
        wd = 1'b1;
        push(r0 + 100, 3'b000, 1'b0, 8'd0);
`endif
        // Clean bring-up: RELEASE 19 edges after the raw lock, then one bit per 4 edges.
        a = r0 + 110;
        wait_to(a);
        pll_locked = 3'b111;
        push(a + 23, 3'b001, 1'b0, 8'd0);
        push(a + 27, 3'b011, 1'b0, 8'd0);
        push(a + 31, 3'b111, 1'b1, 8'd0);

        // Loss in RUN; lock returns during FAULT so the 8-cycle hold sets the rerun time.
        b = a + 40;
        wait_to(b);
        pll_locked[1] = 1'b0;
        push(b + 3, 3'b000, 1'b0, 8'd1);
        wait_to(b + 2);
        pll_locked[1] = 1'b1;
        push(b + 32, 3'b001, 1'b0, 8'd1);
        push(b + 36, 3'b011, 1'b0, 8'd1);
        push(b + 40, 3'b111, 1'b1, 8'd1);

        // Loss coincident with the second release step: 001 goes straight to 000.
        c = b + 50;
        wait_to(c);
        pll_locked[0] = 1'b0;
        push(c + 3, 3'b000, 1'b0, 8'd2);
        wait_to(c + 2);
        pll_locked[0] = 1'b1;
        push(c + 32, 3'b001, 1'b0, 8'd2);
        wait_to(c + 33);
        pll_locked[0] = 1'b0;
        push(c + 36, 3'b000, 1'b0, 8'd3);
        wait_to(c + 35);
        pll_locked[0] = 1'b1;
        push(c + 65, 3'b001, 1'b0, 8'd3);
        push(c + 69, 3'b011, 1'b0, 8'd3);
        push(c + 73, 3'b111, 1'b1, 8'd3);

        // Glitch at stable count 10 restarts the full count and is not a loss.
        d = c + 80;
        wait_to(d);
        pll_locked = 3'b000;
        push(d + 3, 3'b000, 1'b0, 8'd4);
        g = d + 20;
        wait_to(g);
        pll_locked = 3'b111;
        wait_to(g + 12);
        pll_locked[0] = 1'b0;
        wait_to(g + 15);
        pll_locked[0] = 1'b1;
        push(g + 38, 3'b001, 1'b0, 8'd4);
        push(g + 42, 3'b011, 1'b0, 8'd4);
        push(g + 46, 3'b111, 1'b1, 8'd4);

        // Asynchronous reset in the middle of RELEASE.
        e = g + 60;
        wait_to(e);
        pll_locked = 3'b000;
        push(e + 3, 3'b000, 1'b0, 8'd5);
        f = e + 20;
        wait_to(f);
        pll_locked = 3'b111;
        push(f + 23, 3'b001, 1'b0, 8'd5);
        wait_to(f + 25);
        #1 rst_n = 1'b0;
        #1 check_now("async_reset");
        wd = 1'b0;
        push(f + 26, 3'b000, 1'b0, 8'd0);
        wait_to(f + 28);
        rst_n = 1'b1;
        push(f + 51, 3'b001, 1'b0, 8'd0);
        push(f + 55, 3'b011, 1'b0, 8'd0);
        push(f + 59, 3'b111, 1'b1, 8'd0);

        wait_to(f + 70);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expectations: got %0d outstanding, required 0 (next cyc=%0d rst=%b)",
                     exp_q.size(), exp_q[0].cyc, exp_q[0].rst);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
